// File: rtl/if_id_buf.sv
// if_id_buf: IF->ID decoupling stage.
// Buffers up to DEPTH fetched {pc, inst} pairs in a circular FIFO in front of
// a registered ID-side output, so fetch can keep running while decode stalls.
//
// Ports:
//   clk, resetn         clock (rising edge), async active-low reset
//   if_valid/pc/inst    fetch-side entry offered this cycle
//   if_ready            buffer can accept an entry (registered state only)
//   stall               pipeline stall vector; stall[STAGE+1] holds ID
//   flush               drop all buffered and output state
//   id_valid/pc/inst    registered output to the decoder (zero on bubble)
//   count               entries held in the FIFO, not counting the output reg
module if_id_buf #(
  parameter int PC_W    = 32,
  parameter int INST_W  = 32,
  parameter int DEPTH   = 4,
  parameter int STALL_W = 6,
  parameter int STAGE   = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       if_valid,
  input  logic [PC_W-1:0]            if_pc,
  input  logic [INST_W-1:0]          if_inst,
  output logic                       if_ready,
  input  logic [STALL_W-1:0]         stall,
  input  logic                       flush,
  output logic                       id_valid,
  output logic [PC_W-1:0]            id_pc,
  output logic [INST_W-1:0]          id_inst,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t [DEPTH-1:0] mem_q;
  ent_t             out_q, out_d;
  logic             vld_q, vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push, adv, empty, wr_en, pop;

  // Only the ID-side bit matters here; fetch-side stalling arrives via if_valid.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign if_ready = (count_q != FULL);
  assign push     = if_valid & if_ready & ~flush;
  assign adv      = ~stall[STAGE+1];
  assign empty    = (count_q == '0);

  // An empty FIFO with ID advancing bypasses straight to the output reg,
  // so the entry is never written to storage.
  assign wr_en = push & ~(adv & empty);
  assign pop   = adv & ~empty & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    out_d    = out_q;
    vld_d    = vld_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      out_d    = '0;
      vld_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (adv) begin
        if (!empty) begin
          out_d = mem_q[rd_ptr_q];
          vld_d = 1'b1;
        end else if (push) begin
          out_d = '{pc: if_pc, inst: if_inst};
          vld_d = 1'b1;
        end else begin
          out_d = '0;
          vld_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      out_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
    end
  end

  // Storage contents are don't-care after reset; the pointers/count gate use.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{pc: if_pc, inst: if_inst};
  end

  assign id_valid = vld_q;
  assign id_pc    = out_q.pc;
  assign id_inst  = out_q.inst;
  assign count    = count_q;

endmodule

// File: tb/tb_if_id_buf.sv
module tb_if_id_buf;

  localparam int PC_W = 32, INST_W = 32, DEPTH = 4, STALL_W = 6, STAGE = 1;
  localparam logic [STALL_W-1:0] ID_STALL = 6'b000100;

  logic              clk = 1'b0;
  logic              resetn;
  logic              if_valid;
  logic [PC_W-1:0]   if_pc;
  logic [INST_W-1:0] if_inst;
  logic              if_ready;
  logic [STALL_W-1:0] stall;
  logic              flush;
  logic              id_valid;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  logic [$clog2(DEPTH):0] count;

  if_id_buf #(.PC_W(PC_W), .INST_W(INST_W), .DEPTH(DEPTH),
              .STALL_W(STALL_W), .STAGE(STAGE)) dut (
    .clk(clk), .resetn(resetn), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(if_ready), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending entries plus the visible ID slot.
  logic [PC_W-1:0]   m_pc[$];
  logic [INST_W-1:0] m_inst[$];
  logic              e_vld;
  logic [PC_W-1:0]   e_pc;
  logic [INST_W-1:0] e_inst;

  task automatic model_clear();
    m_pc.delete(); m_inst.delete();
    e_vld = 1'b0; e_pc = '0; e_inst = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".id_valid"}, 64'(id_valid), 64'(e_vld));
    chk({tag, ".id_pc"},    64'(id_pc),    64'(e_pc));
    chk({tag, ".id_inst"},  64'(id_inst),  64'(e_inst));
    chk({tag, ".count"},    64'(count),    64'(m_pc.size()));
  endtask

  // Called at a negedge: apply one cycle of inputs, clock it, check at the next negedge.
  task automatic step(input string tag, input logic v, input logic [PC_W-1:0] pc,
                      input logic [INST_W-1:0] inst, input logic [STALL_W-1:0] st,
                      input logic fl);
    bit rdy, psh, go;
    rdy = (m_pc.size() != DEPTH);
    chk({tag, ".if_ready"}, 64'(if_ready), 64'(rdy));
    if_valid = v; if_pc = pc; if_inst = inst; stall = st; flush = fl;
    psh = v && rdy && !fl;
    go  = !st[STAGE+1];
    if (fl) begin
      model_clear();
    end else if (!go) begin
      if (psh) begin m_pc.push_back(pc); m_inst.push_back(inst); end
    end else if (m_pc.size() > 0) begin
      e_vld = 1'b1; e_pc = m_pc.pop_front(); e_inst = m_inst.pop_front();
      if (psh) begin m_pc.push_back(pc); m_inst.push_back(inst); end
    end else if (psh) begin
      e_vld = 1'b1; e_pc = pc; e_inst = inst;
    end else begin
      e_vld = 1'b0; e_pc = '0; e_inst = '0;
    end
    @(posedge clk);
    @(negedge clk);
    if_valid = 1'b0; flush = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; stall = '0; flush = 1'b0;
    model_clear();
    #3;
    check_outputs("reset");
    chk("reset.if_ready", 64'(if_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // Stream with no stall: one-cycle latency, FIFO stays empty.
    for (int i = 0; i < 4; i++) step("stream", 1'b1, 32'h100 + 32'(4*i), 32'hA0 + 32'(i), '0, 1'b0);
    // Bubble.
    step("bubble", 1'b0, '0, '0, '0, 1'b0);
    // Fill under stall: fifth entry must be refused.
    for (int i = 0; i < 5; i++) step("fill", 1'b1, 32'h200 + 32'(4*i), 32'hB0 + 32'(i), ID_STALL, 1'b0);
    chk("fill.full_count", 64'(count), 64'(DEPTH));
    for (int i = 0; i < 5; i++) step("drain", 1'b0, '0, '0, '0, 1'b0);
    // Simultaneous push/pop at count=2.
    for (int i = 0; i < 2; i++) step("pp_fill", 1'b1, 32'h300 + 32'(4*i), 32'hC0 + 32'(i), ID_STALL, 1'b0);
    step("pushpop", 1'b1, 32'h308, 32'hC2, '0, 1'b0);
    for (int i = 0; i < 3; i++) step("pp_drain", 1'b0, '0, '0, '0, 1'b0);
    // Flush mid-backlog with a push in the flush cycle, then bypass.
    for (int i = 0; i < 3; i++) step("fl_fill", 1'b1, 32'h400 + 32'(4*i), 32'hD0 + 32'(i), ID_STALL, 1'b0);
    step("flush", 1'b1, 32'h4FC, 32'hDF, '0, 1'b1);
    step("post_flush", 1'b1, 32'h500, 32'hE0, '0, 1'b0);
    // Async reset with count=2, observed before any clock edge.
    for (int i = 0; i < 2; i++) step("ar_fill", 1'b1, 32'h600 + 32'(4*i), 32'hF0 + 32'(i), ID_STALL, 1'b0);
    #1 resetn = 1'b0;
    #1;
    model_clear();
    check_outputs("async_rst");
    chk("async_rst.if_ready", 64'(if_ready), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    stall = '0;

    // Random traffic with phases of light and heavy ID stalling.
    for (int i = 0; i < 1500; i++) begin
      logic [STALL_W-1:0] st;
      int pct;
      pct = ((i / 100) % 2 == 0) ? 20 : 70;
      st = STALL_W'($urandom);
      st[STAGE+1] = ($urandom_range(99) < pct);
      step("rand", ($urandom_range(99) < 75), $urandom, $urandom, st, ($urandom_range(99) < 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
Name: if_id_buf

Overview:
- Parametrised IF→ID decoupling stage and successor to the single-register IF/ID latch.
- Holds up to DEPTH fetched {pc, inst} pairs in a circular FIFO, followed by a registered ID-side output.
- Fetch keeps running while decode is stalled; the stage absorbs the backlog. Flush and stall-vector semantics match the rest of the pipeline.
- Sits between the fetch unit and the decoder.

Parameters:
- PC_W, 32, width of pc field
- INST_W, 32, width of instruction field
- DEPTH, 4, FIFO entries; power of two, ≥2
- STALL_W, 6, width of pipeline stall vector
- STAGE, 1, index of this stage in the stall vector; STAGE+1 < STALL_W

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  reset, asynchronous, active-low
- if_valid  in  1  fetch presents a valid entry this cycle
- if_pc  in  PC_W  fetched pc
- if_inst  in  INST_W  fetched instruction
- if_ready  out  1  buffer can accept an entry this cycle
- stall  in  STALL_W  pipeline stall vector; 1 = stop
- flush  in  1  discard all buffered and output state
- id_valid  out  1  id_pc/id_inst hold a real instruction
- id_pc  out  PC_W  pc to decode; 0 when bubble
- id_inst  out  INST_W  instruction to decode; 0 when bubble
- count  out  clog2(DEPTH)+1  entries currently in FIFO, excluding the output register

Behaviour:
- Reset (async, resetn=0): id_pc=0, id_inst=0, id_valid=0, count=0, rd/wr pointers=0. if_ready=1 once count=0. FIFO storage contents are don't-care.
- if_ready = (count != DEPTH). It is a function of registered state only; there is no same-cycle pop fall-through, so a full buffer refuses a push even in a cycle where it pops.
- push = if_valid & if_ready & ~flush.
- adv = (stall[STAGE+1] == 0), meaning ID may take a new instruction.
- Flush (priority over everything except reset):
  - next edge: count=0, pointers=0, id_pc=0, id_inst=0, id_valid=0
  - any push in the flush cycle is dropped
- adv=0 and no flush:
  - id_* and id_valid hold
  - push writes at wr_ptr; wr_ptr++ mod DEPTH; count++
- adv=1 and no flush:
  - count>0: output register loads the FIFO head (rd_ptr) with id_valid=1; rd_ptr++.
    - A simultaneous push writes the tail and count is unchanged.
    - Without a push, count--.
  - count=0 and push (bypass): output register loads if_pc/if_inst directly with id_valid=1. FIFO is untouched, count stays 0.
  - count=0 and no push: bubble. id_pc=0, id_inst=0, id_valid=0.
- Latency:
  - empty buffer and adv=1: an entry presented before edge N is on id_* after edge N (1 cycle, same as the old latch)
  - each buffered entry adds one cycle
- Ordering: strict FIFO; entries leave in push order. No entry is duplicated or lost except by flush.
- Pointers wrap modulo DEPTH; count saturates structurally because push is gated by if_ready.
- stall[STAGE] is not used internally. Fetch-side stalling is expressed through if_valid.
- Width rules: count is unsigned; no pc arithmetic occurs in this block.

Test Plan:
- Reset then stream:
  - stimulus: stall=0; push pc=0x100..0x10C, inst=0xA0..0xA3, one per cycle
  - response: id_pc follows 1 cycle later (0x100 after first edge); count stays 0; id_valid=1 throughout
- Fill under stall:
  - stimulus: stall=6'b000100; push 5 entries (DEPTH=4)
  - response: count reaches 4; if_ready=0 on the 5th; the 5th is not accepted; id_* held
  - then release stall: id_pc emits entries in order, one per cycle; count decrements 4→0
- Simultaneous push/pop at count=2:
  - response: count stays 2; output equals old head; new entry appears 3 cycles later
- Bubble:
  - stimulus: empty buffer, stall=0, if_valid=0
  - response: id_pc=0, id_inst=0, id_valid=0 after the edge
- Flush mid-backlog:
  - stimulus: count=3, flush=1 with if_valid=1
  - response: next cycle count=0, id_valid=0, id_*=0; pushed entry discarded; next push bypasses with 1-cycle latency
- Async reset mid-operation:
  - stimulus: resetn low between edges with count=2
  - response: outputs zero immediately without a clock edge; if_ready=1
